// File: rtl/fetch_requester.sv
// Instruction-fetch initiator: owns the PC, issues one word request at a time, and buffers
// returned words with their PCs in a small in-order queue for decode. Supports redirect/flush.
module fetch_requester #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          MEM_SIZE = 1024,
    parameter int          ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [31:0]        req_pc_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [31:0]        q_data_q [DEPTH];
    logic [31:0]        q_pc_q   [DEPTH];

    logic               push;
    logic               pop;
    logic               req_fire;
    logic [CNT_W:0]     credit_used;

    assign inst_valid = rst_n && (count_q != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign push       = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

    // Queue slots already claimed: entries that stay after this cycle's pop plus the outstanding
    // request. A response landing now converts outstanding into an entry, so the sum is unchanged.
    assign credit_used = {1'b0, count_q} - (CNT_W+1)'(pop) + (CNT_W+1)'(state_q == S_WAIT);

    assign imem_req_valid = rst_n && !redirect_valid && ((state_q == S_REQ) || push)
                            && (credit_used < (CNT_W+1)'(DEPTH));
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign imem_addr = pc_q[ADDR_W+1:2];

    assign inst_data = inst_valid ? q_data_q[rd_ptr_q] : 32'h0;
    assign inst_pc   = inst_valid ? q_pc_q[rd_ptr_q]   : 32'h0;

    always_comb begin
        count_d = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (redirect_valid) begin
                pc_q     <= redirect_pc & ~32'h3;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                // An outstanding request whose response is still to come must be swallowed.
                state_q  <= ((state_q != S_REQ) && !imem_rsp_valid) ? S_DROP : S_REQ;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (req_fire) begin
                    pc_q    <= pc_q + 32'd4;
                    state_q <= S_WAIT;
                end else begin
                    case (state_q)
                        S_WAIT:  if (imem_rsp_valid) state_q <= S_REQ;
                        S_DROP:  if (imem_rsp_valid) state_q <= S_REQ;
                        default: state_q <= S_REQ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) req_pc_q <= pc_q;
        if (push) begin
            q_data_q[wr_ptr_q] <= imem_rsp_data;
            q_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_requester.sv
// Directed bench for fetch_requester: cycle-by-cycle vector table plus a streaming/stall
// sequence against a 1-cycle behavioural instruction memory.
module tb_fetch_requester;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [31:0]       inst_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    fetch_requester #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .MEM_SIZE (1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        dv;
        logic [31:0] dpc;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_idata;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] d(input int n);
        return 32'hD000_0000 + 32'(n);
    endfunction

    function automatic vec_t v(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic dv, input logic [31:0] dpc,
                               input logic rqv, input logic [31:0] addr, input logic iv,
                               input logic [31:0] ipc, input logic [31:0] idata);
        vec_t t;
        t.rst_n = r;  t.rr = rr;  t.rv = rv;  t.rd = rd;  t.ir = ir;  t.dv = dv;  t.dpc = dpc;
        t.e_rqv = rqv;  t.e_addr = addr;  t.e_iv = iv;  t.e_ipc = ipc;  t.e_idata = idata;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int          pops;
    int          occ;
    logic        pend;
    logic [9:0]  pend_addr;
    logic [31:0] exp_pc;
    logic [9:0]  exp_addr;

    initial begin
        // rst rr rv rd     ir dv dpc            | rqv addr   iv ipc            idata
        vecs.push_back(v(0,1,0,0,    1,0,0,            0,0,     0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            1,0,     0,0,            0));
        vecs.push_back(v(1,1,1,d(0), 1,0,0,            1,1,     0,0,            0));
        vecs.push_back(v(1,1,1,d(1), 1,0,0,            1,2,     1,0,            d(0)));
        vecs.push_back(v(1,1,1,d(2), 1,0,0,            1,3,     1,4,            d(1)));
        vecs.push_back(v(1,1,1,d(3), 0,0,0,            0,4,     1,8,            d(2)));
        for (int k = 0; k < 3; k++)
            vecs.push_back(v(1,1,0,0, 0,0,0,           0,4,     1,8,            d(2)));
        vecs.push_back(v(1,1,0,0,    1,0,0,            1,4,     1,8,            d(2)));
        vecs.push_back(v(1,1,1,d(4), 1,0,0,            1,5,     1,12,           d(3)));
        vecs.push_back(v(1,1,1,d(5), 1,0,0,            1,6,     1,16,           d(4)));
        // redirect together with a response and a pop
        vecs.push_back(v(1,1,1,d(6), 1,1,32'h100,      0,7,     1,20,           d(5)));
        vecs.push_back(v(1,1,0,0,    1,0,0,            1,'h40,  0,0,            0));
        vecs.push_back(v(1,1,1,d(7), 1,0,0,            1,'h41,  0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,'h42,  1,32'h100,      d(7)));
        // redirect while waiting on a 3-cycle memory
        vecs.push_back(v(1,1,0,0,    1,1,32'h40,       0,'h42,  0,0,            0));
        vecs.push_back(v(1,1,1,d(8), 1,0,0,            0,'h10,  0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            1,'h10,  0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,'h11,  0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,'h11,  0,0,            0));
        vecs.push_back(v(1,1,1,d(9), 1,0,0,            1,'h11,  0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,'h12,  1,32'h40,       d(9)));
        // memory not ready
        vecs.push_back(v(1,0,1,d(10),1,0,0,            1,'h12,  0,0,            0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v(1,0,0,0, 0,0,0,           1,'h12,  1,32'h44,       d(10)));
        vecs.push_back(v(1,1,0,0,    1,0,0,            1,'h12,  1,32'h44,       d(10)));
        vecs.push_back(v(1,1,1,d(11),1,0,0,            1,'h13,  0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,'h14,  1,32'h48,       d(11)));
        // redirect to an unaligned top-of-space PC, then wrap
        vecs.push_back(v(1,1,1,d(12),1,0,0,            1,'h14,  0,0,            0));
        vecs.push_back(v(1,1,1,d(13),1,1,32'hFFFF_FFFE,0,'h15,  1,32'h4C,       d(12)));
        vecs.push_back(v(1,1,0,0,    1,0,0,            1,'h3FF, 0,0,            0));
        vecs.push_back(v(1,1,1,d(14),1,0,0,            1,0,     0,0,            0));
        vecs.push_back(v(1,1,1,d(15),1,0,0,            1,1,     1,32'hFFFF_FFFC,d(14)));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,2,     1,0,            d(15)));
        // reset mid-operation with a late response afterwards
        vecs.push_back(v(0,1,0,0,    1,0,0,            0,2,     0,0,            0));
        vecs.push_back(v(1,1,1,d(16),1,0,0,            1,0,     0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,1,     0,0,            0));
        vecs.push_back(v(1,1,1,d(17),1,0,0,            1,1,     0,0,            0));
        vecs.push_back(v(1,1,0,0,    1,0,0,            0,2,     1,0,            d(17)));

        rst_n = 1'b0;  imem_req_ready = 1'b0;  imem_rsp_valid = 1'b0;  imem_rsp_data = 32'h0;
        inst_ready = 1'b0;  redirect_valid = 1'b0;  redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n          = vecs[i].rst_n;
            imem_req_ready = vecs[i].rr;
            imem_rsp_valid = vecs[i].rv;
            imem_rsp_data  = vecs[i].rd;
            inst_ready     = vecs[i].ir;
            redirect_valid = vecs[i].dv;
            redirect_pc    = vecs[i].dpc;
            #1;
            chk($sformatf("row%0d.req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rqv));
            chk($sformatf("row%0d.addr", i),      32'(imem_addr),      vecs[i].e_addr);
            chk($sformatf("row%0d.inst_valid", i), 32'(inst_valid),    32'(vecs[i].e_iv));
            chk($sformatf("row%0d.inst_pc", i),   inst_pc,             vecs[i].e_ipc);
            chk($sformatf("row%0d.inst_data", i), inst_data,           vecs[i].e_idata);
            @(negedge clk);
        end

        // Streaming with a 1-cycle memory and a 10-cycle decode stall.
        rst_n = 1'b0;  imem_rsp_valid = 1'b0;  redirect_valid = 1'b0;
        @(negedge clk);
        pops = 0;  occ = 0;  pend = 1'b0;  pend_addr = '0;  exp_pc = 32'h0;  exp_addr = '0;
        for (int c = 0; c < 30; c++) begin
            rst_n          = 1'b1;
            imem_req_ready = 1'b1;
            redirect_valid = 1'b0;
            imem_rsp_valid = pend;
            imem_rsp_data  = 32'hC0DE_0000 ^ {22'h0, pend_addr};
            inst_ready     = !(c >= 5 && c < 15);
            #1;
            if (inst_valid && inst_ready) begin
                chk($sformatf("stream%0d.inst_pc", c), inst_pc, exp_pc);
                chk($sformatf("stream%0d.inst_data", c), inst_data,
                    32'hC0DE_0000 ^ {22'h0, exp_pc[11:2]});
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (imem_req_valid && imem_req_ready) begin
                chk($sformatf("stream%0d.addr", c), 32'(imem_addr), 32'(exp_addr));
                exp_addr = exp_addr + 10'd1;
            end
            if (c >= 6 && c < 15)
                chk($sformatf("stall%0d.req_valid", c), 32'(imem_req_valid), 32'd0);
            occ = occ + int'(pend) - int'(inst_valid && inst_ready);
            if (c == 14) chk("stall.queued", 32'(occ), 32'd2);
            pend      = imem_req_valid && imem_req_ready;
            pend_addr = imem_addr;
            @(negedge clk);
        end
        chk("stream.pops", 32'(pops), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
